// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = 4 * NUM_DIGITS;

    typedef logic [3:0] nibble_t;
    typedef logic [1:0] dig_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    // Digit 0 lives in the low nibble, digit 3 in the high nibble.
    function automatic nibble_t nibble_of(input logic [VALUE_W-1:0] value, input dig_sel_t sel);
        return value[{sel, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load handshake between a display data producer and the scan controller.
interface display_scan_ctrl_if;
    import display_pkg::*;

    logic                  load_valid;
    logic                  load_ready;
    logic [VALUE_W-1:0]    load_value;
    logic [NUM_DIGITS-1:0] load_dots;

    modport master (output load_valid, load_value, load_dots, input load_ready);
    modport slave  (input load_valid, load_value, load_dots, output load_ready);

endinterface

// File: rtl/display_scan_ctrl_lzb_mask.sv
// Leading-zero blanking mask: digit i is blanked when it and every digit above it are zero.
module lzb_mask
    import display_pkg::*;
(
    input  logic [VALUE_W-1:0]    value,
    input  logic                  lzb_en,
    output logic [NUM_DIGITS-1:0] mask
);

    // zero_above[i] = digits NUM_DIGITS-1 down to i are all zero.
    logic [NUM_DIGITS:1] zero_above;

    assign zero_above[NUM_DIGITS] = 1'b1;
    assign mask[0]                = 1'b0;

    generate
        for (genvar gi = NUM_DIGITS - 1; gi >= 1; gi--) begin : g_digit
            assign zero_above[gi] = zero_above[gi + 1] && (value[4*gi +: 4] == 4'h0);
            assign mask[gi]       = lzb_en && zero_above[gi];
        end
    endgenerate

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scan sequencer with per-slot anti-ghost blanking, frame-aligned double-buffered
// display data behind a valid/ready load port, and leading-zero blanking.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                lzb_en,
    display_scan_ctrl_if.slave  load_if,
    output dig_sel_t            dig_sel,
    output logic                digit_en,
    output nibble_t             nibble,
    output logic                dot,
    output logic                blank,
    output logic                frame_done
);

    generate
        if (BLANK_CYCLES < 1 || TICK_DIV < BLANK_CYCLES + 1) begin : g_param_check
            $error("display_scan_ctrl: need BLANK_CYCLES >= 1 and TICK_DIV >= BLANK_CYCLES + 1");
        end
    endgenerate

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t BLANK_LAST = cnt_t'(BLANK_CYCLES - 1);
    localparam cnt_t TICK_LAST  = cnt_t'(TICK_DIV - 1);
    localparam dig_sel_t LAST_DIGIT = dig_sel_t'(NUM_DIGITS - 1);

    state_t                state_reg;
    cnt_t                  cnt_reg;
    dig_sel_t              sel_reg;
    logic                  digit_en_reg;
    nibble_t               nibble_reg;
    logic                  dot_reg;
    logic                  blank_reg;
    logic                  frame_done_reg;
    logic [VALUE_W-1:0]    active_value_reg;
    logic [NUM_DIGITS-1:0] active_dots_reg;
    logic [VALUE_W-1:0]    pend_value_reg;
    logic [NUM_DIGITS-1:0] pend_dots_reg;
    logic                  pending_reg;

    logic                  slot_end;
    logic                  last_sel;
    logic                  boundary;
    logic                  apply;
    logic                  load_fire;
    cnt_t                  cnt_inc;
    logic                  cnt_inc_last;
    dig_sel_t              sel_next;
    logic [VALUE_W-1:0]    active_value_next;
    logic [NUM_DIGITS-1:0] active_dots_next;
    logic [NUM_DIGITS-1:0] mask_next;

    assign slot_end     = (state_reg == ON) && (cnt_reg == TICK_LAST);
    assign last_sel     = (sel_reg == LAST_DIGIT);
    assign boundary     = slot_end && last_sel;
    assign cnt_inc      = cnt_reg + cnt_t'(1);
    assign cnt_inc_last = (cnt_inc == TICK_LAST);
    assign load_fire    = load_if.load_valid && !pending_reg;

    // Pending data is promoted only between frames, or immediately when no frame runs.
    assign apply = pending_reg && (boundary || state_reg == IDLE);

    assign sel_next = (!enable || state_reg == IDLE) ? dig_sel_t'(0)
                    : (slot_end ? sel_reg + dig_sel_t'(1) : sel_reg);

    assign active_value_next = apply ? pend_value_reg : active_value_reg;
    assign active_dots_next  = apply ? pend_dots_reg  : active_dots_reg;

    // Mask is taken from the post-update data so blank lines up with nibble.
    lzb_mask u_lzb_mask (
        .value  (active_value_next),
        .lzb_en (lzb_en),
        .mask   (mask_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            sel_reg          <= '0;
            digit_en_reg     <= 1'b0;
            nibble_reg       <= '0;
            dot_reg          <= 1'b0;
            blank_reg        <= 1'b0;
            frame_done_reg   <= 1'b0;
            active_value_reg <= '0;
            active_dots_reg  <= '0;
            pend_value_reg   <= '0;
            pend_dots_reg    <= '0;
            pending_reg      <= 1'b0;
        end else begin
            sel_reg          <= sel_next;
            active_value_reg <= active_value_next;
            active_dots_reg  <= active_dots_next;
            nibble_reg       <= nibble_of(active_value_next, sel_next);
            dot_reg          <= active_dots_next[sel_next];
            blank_reg        <= mask_next[sel_next];

            if (apply) begin
                pending_reg <= 1'b0;
            end
            if (load_fire) begin
                pend_value_reg <= load_if.load_value;
                pend_dots_reg  <= load_if.load_dots;
                pending_reg    <= 1'b1;
            end

            if (!enable) begin
                state_reg      <= IDLE;
                cnt_reg        <= '0;
                digit_en_reg   <= 1'b0;
                frame_done_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg      <= BLANK;
                        cnt_reg        <= '0;
                        digit_en_reg   <= 1'b0;
                        frame_done_reg <= 1'b0;
                    end
                    BLANK: begin
                        cnt_reg <= cnt_inc;
                        if (cnt_reg == BLANK_LAST) begin
                            state_reg      <= ON;
                            digit_en_reg   <= 1'b1;
                            frame_done_reg <= cnt_inc_last && last_sel;
                        end
                    end
                    ON: begin
                        if (slot_end) begin
                            state_reg      <= BLANK;
                            cnt_reg        <= '0;
                            digit_en_reg   <= 1'b0;
                            frame_done_reg <= 1'b0;
                        end else begin
                            cnt_reg        <= cnt_inc;
                            frame_done_reg <= cnt_inc_last && last_sel;
                        end
                    end
                    default: begin
                        state_reg      <= IDLE;
                        cnt_reg        <= '0;
                        digit_en_reg   <= 1'b0;
                        frame_done_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign load_if.load_ready = !pending_reg;
    assign dig_sel            = sel_reg;
    assign digit_en           = digit_en_reg;
    assign nibble             = nibble_reg;
    assign dot                = dot_reg;
    assign blank              = blank_reg;
    assign frame_done         = frame_done_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed stimulus with a per-slot scoreboard monitor.
module tb_display_scan_ctrl;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       lzb_en;
    logic [1:0] dig_sel;
    logic       digit_en;
    logic [3:0] nibble;
    logic       dot;
    logic       blank;
    logic       frame_done;

    display_scan_ctrl_if lif ();

    display_scan_ctrl #(
        .TICK_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .lzb_en     (lzb_en),
        .load_if    (lif),
        .dig_sel    (dig_sel),
        .digit_en   (digit_en),
        .nibble     (nibble),
        .dot        (dot),
        .blank      (blank),
        .frame_done (frame_done)
    );

    int total = 0;
    int bad   = 0;

    // Expected slot record: {dig_sel, nibble, blank, dot}
    logic [7:0] exp_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic push_frame(input int first, input logic [15:0] value,
                              input logic [3:0] dots, input logic [3:0] mask);
        for (int i = first; i < 4; i++) begin
            logic [1:0] s;
            s = i[1:0];
            exp_q.push_back({s, value[4*i +: 4], mask[i], dots[i]});
        end
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_done && n < 64);
        if (!frame_done) timeout(name);
    endtask

    task automatic wait_slot(input logic [1:0] s, input logic en, input string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(dig_sel == s && digit_en == en) && n < 64);
        if (!(dig_sel == s && digit_en == en)) timeout(name);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            timeout(name);
            exp_q.delete();
        end
    endtask

    task automatic load(input logic [15:0] value, input logic [3:0] dots);
        lif.load_valid = 1'b1;
        lif.load_value = value;
        lif.load_dots  = dots;
        @(negedge clock);
        lif.load_valid = 1'b0;
    endtask

    // Monitor: on each digit turn-on, compare the slot contents against the next expectation.
    initial begin
        logic       de_prev;
        logic [7:0] e;
        de_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (digit_en && !de_prev && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({dig_sel, nibble, blank, dot} !== e) begin
                    bad++;
                    $display("FAIL slot: got sel=%0d nib=%h blank=%b dot=%b want sel=%0d nib=%h blank=%b dot=%b",
                             dig_sel, nibble, blank, dot, e[7:6], e[5:2], e[1], e[0]);
                end else begin
                    $display("slot sel=%0d nib=%h blank=%b dot=%b ok", dig_sel, nibble, blank, dot);
                end
            end
            de_prev = digit_en;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        enable         = 1'b0;
        lzb_en         = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_value = '0;
        lif.load_dots  = '0;

        repeat (3) @(negedge clock);
        chk("rst_dig_sel", dig_sel, 0);
        chk("rst_digit_en", digit_en, 0);
        chk("rst_nibble", nibble, 0);
        chk("rst_dot", dot, 0);
        chk("rst_blank", blank, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_load_ready", lif.load_ready, 1);

        // Scan timing: 8-cycle slots, 2 dark then 6 lit, frame_done in last cycle of slot 3.
        reset  = 1'b1;
        enable = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            int p;
            int s;
            logic [3:0] want;
            @(negedge clock);
            p = (n - 1) % 8;
            s = ((n - 1) / 8) % 4;
            want = {(p >= 2) ? 1'b1 : 1'b0, s[1:0], (p == 7 && s == 3) ? 1'b1 : 1'b0};
            chk($sformatf("timing_c%0d", n), {digit_en, dig_sel, frame_done}, want);
        end
        $display("timing sweep of 40 cycles done");

        // Leading-zero blanking on 0x00A5.
        lzb_en = 1'b1;
        load(16'h00A5, 4'b0101);
        wait_frame("lzb_a5_wait");
        push_frame(0, 16'h00A5, 4'b0101, 4'b1100);
        drain("lzb_a5_drain");

        // All-zero value: only digit 0 stays visible.
        load(16'h0000, 4'b0000);
        wait_frame("lzb_zero_wait");
        push_frame(0, 16'h0000, 4'b0000, 4'b1110);
        drain("lzb_zero_drain");

        // Blanking disabled: leading zeros shown.
        lzb_en = 1'b0;
        load(16'h0050, 4'b0010);
        wait_frame("lzb_off_wait");
        push_frame(0, 16'h0050, 4'b0010, 4'b0000);
        drain("lzb_off_drain");

        // Mid-frame load plus a second load held until ready returns.
        wait_slot(2'd1, 1'b0, "hs_wait");
        push_frame(1, 16'h0050, 4'b0010, 4'b0000);
        lif.load_valid = 1'b1;
        lif.load_value = 16'h1234;
        lif.load_dots  = 4'b1000;
        @(negedge clock);
        chk("hs_ready_low", lif.load_ready, 0);
        lif.load_value = 16'h5678;
        lif.load_dots  = 4'b0110;
        begin
            int n = 0;
            do begin
                @(negedge clock);
                n++;
                chk("hs_ready_held", lif.load_ready, 0);
            end while (!frame_done && n < 64);
            if (!frame_done) timeout("hs_boundary_wait");
        end
        push_frame(0, 16'h1234, 4'b1000, 4'b0000);
        @(negedge clock);
        chk("hs_ready_back", lif.load_ready, 1);
        @(negedge clock);
        lif.load_valid = 1'b0;
        chk("hs_second_taken", lif.load_ready, 0);
        wait_frame("hs_second_wait");
        push_frame(0, 16'h5678, 4'b0110, 4'b0000);
        drain("hs_drain");

        // Enable drop during slot 2, a load applied while idle, then re-enable.
        wait_slot(2'd2, 1'b1, "drop_wait");
        enable = 1'b0;
        @(negedge clock);
        chk("drop_off", {digit_en, dig_sel, frame_done}, 0);
        lif.load_valid = 1'b1;
        lif.load_value = 16'h0009;
        lif.load_dots  = 4'b0001;
        @(negedge clock);
        lif.load_valid = 1'b0;
        chk("idle_pending", lif.load_ready, 0);
        chk("idle_held", {digit_en, dig_sel}, 0);
        @(negedge clock);
        chk("idle_apply", {nibble, dot, lif.load_ready}, {4'h9, 1'b1, 1'b1});
        enable = 1'b1;
        @(negedge clock);
        chk("reen_c0", {digit_en, dig_sel}, 0);
        @(negedge clock);
        chk("reen_c1", {digit_en, dig_sel}, 0);
        @(negedge clock);
        chk("reen_c2", {digit_en, dig_sel, nibble}, {1'b1, 2'd0, 4'h9});

        // Load accepted in the boundary cycle waits a full frame.
        wait_frame("bnd_wait");
        lif.load_valid = 1'b1;
        lif.load_value = 16'h4321;
        lif.load_dots  = 4'b0000;
        push_frame(0, 16'h0009, 4'b0001, 4'b0000);
        @(negedge clock);
        lif.load_valid = 1'b0;
        chk("bnd_taken", lif.load_ready, 0);
        wait_frame("bnd_next_wait");
        push_frame(0, 16'h4321, 4'b0000, 4'b0000);
        drain("bnd_drain");

        // Asynchronous reset mid-ON with pending data.
        wait_slot(2'd1, 1'b1, "ar_wait");
        lif.load_valid = 1'b1;
        lif.load_value = 16'hFFFF;
        lif.load_dots  = 4'b1111;
        @(negedge clock);
        lif.load_valid = 1'b0;
        chk("ar_pending", lif.load_ready, 0);
        chk("ar_pre_state", {digit_en, dig_sel, nibble}, {1'b1, 2'd1, 4'h2});
        #2;
        reset = 1'b0;
        #1;
        chk("ar_outputs", {digit_en, dig_sel, nibble, dot, blank, frame_done, lif.load_ready},
            {1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("ar_after", {digit_en, dig_sel, nibble, lif.load_ready}, {1'b1, 2'd0, 4'h0, 1'b1});
        wait_frame("ar_frame_wait");
        push_frame(0, 16'h0000, 4'b0000, 4'b0000);
        drain("ar_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
